controlo_conversao: RTL
=======================

CONTROLO_CONVERSAO -- requirements
Module: controlo_conversao

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 Port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising clk edge.
REQ-004 Port add_valid, input, 1 bit: request to add add_centimos to the running total.
REQ-005 Port add_centimos, input, 10 bits: item price in cents, unsigned 0..1023.
REQ-006 Port conv_req, input, 1 bit: request to convert the running total to euros.
REQ-007 Port clear, input, 1 bit: zero the running total and the results.
REQ-008 Port ready, output, 1 bit: high when the state is IDLE, meaning requests are accepted.
REQ-009 Port busy, output, 1 bit: high when the state is CONV or DONE.
REQ-010 Port done, output, 1 bit: single-cycle pulse high while the state is DONE.
REQ-011 Port total, output, 14 bits: running total in cents, 0..9999.
REQ-012 Port eurosinteiros, output, 7 bits: whole euros of the last conversion, 0..99.
REQ-013 Port eurosfracao, output, 7 bits: cents remainder of the last conversion, 0..99.
REQ-014 Port overflow, output, 1 bit: sticky flag, set when the total has saturated.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-016 Requests SHALL be sampled only in IDLE, with priority clear > add_valid > conv_req; only the highest-priority asserted request acts, and the others are dropped, not queued.
REQ-017 On clear in IDLE: total, eurosinteiros, eurosfracao and overflow SHALL become 0 on the next edge.
REQ-018 On add_valid in IDLE:
- total SHALL become min(total + add_centimos, 9999);
- overflow SHALL be set if the unsaturated sum exceeds 9999;
- the state SHALL remain IDLE.
REQ-019 On conv_req in IDLE (the accept cycle k): the working remainder SHALL load total, the quotient counter SHALL load 0, and the state SHALL go to CONV.
REQ-020 Each CONV cycle with remainder >= 100 SHALL subtract 100 from the remainder and increment the quotient; exactly one subtraction per cycle.
REQ-021 A CONV cycle with remainder < 100 SHALL:
- register quotient into eurosinteiros;
- register remainder into eurosfracao;
- move the state to DONE.
REQ-022 DONE SHALL last exactly one cycle (done=1) and then return to IDLE.
REQ-023 With N = floor(total/100), done SHALL be high in cycle k+N+2, and ready SHALL be high again in cycle k+N+3.
REQ-024 add_valid, conv_req and clear asserted while busy SHALL be ignored, with no effect on any register.
REQ-025 total SHALL be unchanged by a conversion.
REQ-026 eurosinteiros and eurosfracao SHALL hold their values until the next conversion completes, clear, or reset.
REQ-027 Boundary results SHALL be:
- total=0 gives 0/0 with done at k+2;
- total=100 gives 1/0;
- total=99 gives 0/99;
- total=9999 gives 99/99 with done at k+101.

Reset
REQ-028 When rst_n=0 at a rising edge, in any state including mid-CONV:
- the state SHALL become IDLE;
- total, eurosinteiros, eurosfracao, overflow, done and busy SHALL be 0;
- ready SHALL be 1.
REQ-029 Any in-flight conversion SHALL be abandoned with no done pulse, and requests SHALL be ignored while rst_n=0.

Verification
REQ-030 Reset; add 170; conv_req at cycle k -> done at k+3, eurosinteiros=1, eurosfracao=70, total=170.
REQ-031 Add 1023 ten times -> total=9999, overflow=1; then conv_req -> done at k+101, 99/99.
REQ-032 Clear, then conv_req -> done at k+2, 0/0; then add 100, conv_req -> 1/0.
REQ-033 add_valid and conv_req in the same IDLE cycle -> total updated, no conversion (busy stays 0); add_valid and clear asserted during CONV -> total and results unchanged.
REQ-034 rst_n low for one cycle during CONV of total=500 -> next cycle IDLE, all outputs 0, no done pulse.
REQ-035 clear and add_valid in the same IDLE cycle -> total=0, overflow=0.

Source files
------------

// File: rtl/controlo_conversao.sv
// -----------------------------------------------------------------------------
// controlo_conversao
//
// Cash-register style accumulator with a cents-to-euros converter.
//
// While IDLE the block accepts one request per cycle, in priority order
// clear > add_valid > conv_req. Lower-priority requests that arrive in the
// same cycle are dropped, not queued:
//   clear     : zero the running total, both conversion results and the
//               overflow flag.
//   add_valid : add add_centimos to the running total. The total saturates at
//               9999 and sets the sticky overflow flag when it saturates.
//   conv_req  : split the total into whole euros and remaining cents. The
//               split is done by repeated subtraction of 100, one subtraction
//               per cycle, so a total of T takes floor(T/100) CONV cycles plus
//               one final CONV cycle that registers the results.
//
// Requests that arrive while busy (CONV or DONE) are ignored.
//
// Ports
//   clk           in   1  rising-edge clock
//   rst_n         in   1  synchronous active-low reset
//   add_valid     in   1  add request
//   add_centimos  in  10  price to add, in cents (0..1023)
//   conv_req      in   1  conversion request
//   clear         in   1  clear request
//   ready         out  1  state is IDLE; requests are accepted
//   busy          out  1  state is CONV or DONE
//   done          out  1  one-cycle pulse while the state is DONE
//   total         out 14  running total in cents (0..9999)
//   eurosinteiros out  7  whole euros of the last conversion (0..99)
//   eurosfracao   out  7  cents remainder of the last conversion (0..99)
//   overflow      out  1  sticky: the total has saturated
// -----------------------------------------------------------------------------
module controlo_conversao (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       add_valid,
  input  logic [9:0] add_centimos,
  input  logic       conv_req,
  input  logic       clear,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [13:0] total,
  output logic [6:0] eurosinteiros,
  output logic [6:0] eurosfracao,
  output logic       overflow
);

  localparam logic [14:0] MAX_TOTAL = 15'd9999;
  localparam logic [13:0] CENTS_PER_EURO = 14'd100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Conversion working registers.
  logic [13:0] remainder;
  logic [6:0]  quotient;

  // One bit wider than total so that the largest possible sum
  // (9999 + 1023 = 11022) is seen unsaturated for the overflow decision.
  logic [14:0] sum_raw;
  logic        sum_saturates;

  // Request decode: only one request acts per IDLE cycle.
  logic do_clear;
  logic do_add;
  logic do_conv;

  logic rem_below_euro;

  assign sum_raw        = {1'b0, total} + {5'b0, add_centimos};
  assign sum_saturates  = (sum_raw > MAX_TOTAL);
  assign rem_below_euro = (remainder < CENTS_PER_EURO);

  assign do_clear = (state == IDLE) && clear;
  assign do_add   = (state == IDLE) && !clear && add_valid;
  assign do_conv  = (state == IDLE) && !clear && !add_valid && conv_req;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values of the others, exactly like the
  // hardware flops; blocking (=) here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next is given a default before the case statement so every
  // path assigns it; a missing assignment on some path would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (do_conv) begin
          state_next = CONV;
        end
      end
      CONV: begin
        if (rem_below_euro) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs are pure decodes of the state register, so they are
  // glitch-free relative to the clock and correct immediately after reset.
  assign ready = (state == IDLE);
  assign busy  = (state == CONV) || (state == DONE);
  assign done  = (state == DONE);

  // ---------------------------------------------------------------------------
  // Running total and overflow flag
  // ---------------------------------------------------------------------------
  // Only IDLE requests touch these; a conversion never modifies the total.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total    <= '0;
      overflow <= 1'b0;
    end else if (do_clear) begin
      total    <= '0;
      overflow <= 1'b0;
    end else if (do_add) begin
      if (sum_saturates) begin
        total    <= MAX_TOTAL[13:0];
        overflow <= 1'b1;
      end else begin
        total    <= sum_raw[13:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion datapath
  // ---------------------------------------------------------------------------
  // The working registers are reset as well so that an abandoned conversion
  // leaves no stale state behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remainder <= '0;
      quotient  <= '0;
    end else if (do_conv) begin
      remainder <= total;
      quotient  <= '0;
    end else if ((state == CONV) && !rem_below_euro) begin
      remainder <= remainder - CENTS_PER_EURO;
      quotient  <= quotient + 7'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion results
  // ---------------------------------------------------------------------------
  // Results change only on the final CONV cycle, on clear, or on reset, so
  // they hold the previous answer throughout a new conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eurosinteiros <= '0;
      eurosfracao   <= '0;
    end else if (do_clear) begin
      eurosinteiros <= '0;
      eurosfracao   <= '0;
    end else if ((state == CONV) && rem_below_euro) begin
      eurosinteiros <= quotient;
      // The remainder is below 100 here, so its low 7 bits hold all of it.
      eurosfracao   <= remainder[6:0];
    end
  end

endmodule
